// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the SPI EEPROM command sequencer: opcodes, command encodings,
// FSM states and the byte-plan helpers that map a state to its (byte, hold) pair.
package spi_eeprom_pkg;

  localparam logic [7:0] OpcRead  = 8'h03;
  localparam logic [7:0] OpcWrite = 8'h02;
  localparam logic [7:0] OpcWrdi  = 8'h04;
  localparam logic [7:0] OpcWren  = 8'h06;
  localparam logic [7:0] OpcRdsr  = 8'h05;
  localparam logic [7:0] OpcWrsr  = 8'h01;
  localparam logic [7:0] Dummy    = 8'hFF;

  typedef enum logic [1:0] {
    CmdRead  = 2'b00,
    CmdWrite = 2'b01,
    CmdRdsr  = 2'b10,
    CmdWrsr  = 2'b11
  } cmd_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StWren,
    StOpc,
    StAddrHi,
    StAddrLo,
    StData,
    StPollOpc,
    StPollRd,
    StResp
  } state_e;

  function automatic logic is_write_op(cmd_op_e op);
    return (op == CmdWrite) || (op == CmdWrsr);
  endfunction

  // Byte state that follows st; StPollRd loops back and the caller decides when to stop.
  function automatic state_e next_state(state_e st, cmd_op_e op);
    state_e nxt;
    nxt = StIdle;
    case (st)
      StIdle:    nxt = is_write_op(op) ? StWren : StOpc;
      StWren:    nxt = StOpc;
      StOpc:     nxt = ((op == CmdRead) || (op == CmdWrite)) ? StAddrHi : StData;
      StAddrHi:  nxt = StAddrLo;
      StAddrLo:  nxt = StData;
      StData:    nxt = is_write_op(op) ? StPollOpc : StResp;
      StPollOpc: nxt = StPollRd;
      StPollRd:  nxt = StPollOpc;
      default:   nxt = StIdle;
    endcase
    return nxt;
  endfunction

  // Returns {tx_byte, hold} for a byte state.
  function automatic logic [8:0] byte_of(state_e st, cmd_op_e op, logic [15:0] addr,
                                         logic [7:0] wdata);
    logic [8:0] b;
    b = 9'h000;
    case (st)
      StWren: b = {OpcWren, 1'b0};
      StOpc: begin
        case (op)
          CmdRead:  b = {OpcRead, 1'b1};
          CmdWrite: b = {OpcWrite, 1'b1};
          CmdRdsr:  b = {OpcRdsr, 1'b1};
          default:  b = {OpcWrsr, 1'b1};
        endcase
      end
      StAddrHi:  b = {addr[15:8], 1'b1};
      StAddrLo:  b = {addr[7:0], 1'b1};
      StData:    b = is_write_op(op) ? {wdata, 1'b0} : {Dummy, 1'b0};
      StPollOpc: b = {OpcRdsr, 1'b1};
      StPollRd:  b = {Dummy, 1'b0};
      default:   b = 9'h000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_eeprom_sequencer.sv
// Turns one EEPROM command into the SPI byte sequence, inserting WREN before writes and
// polling RDSR until WIP clears or POLL_MAX reads have been made.
module spi_eeprom_sequencer
  import spi_eeprom_pkg::*;
#(
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic        bus2ip_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        spi_start,
  output logic        spi_hold,
  output logic [7:0]  spi_tx,
  input  logic        spi_ready,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx
);

  localparam logic [9:0] PollMax = POLL_MAX[9:0];

  state_e      state_q;
  logic        issue_q;
  cmd_op_e     op_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [9:0]  poll_cnt_q;

  cmd_op_e     op_in;
  state_e      first_st;
  state_e      adv_st;
  logic [8:0]  first_byte;
  logic [8:0]  adv_byte;
  logic [9:0]  poll_cnt_inc;
  logic        poll_done;
  logic        finish;

  assign op_in     = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  // issue_q only lasts until the engine is seen ready, so a start can never repeat.
  assign spi_start = issue_q & spi_ready;

  always_comb begin
    first_st     = next_state(StIdle, op_in);
    first_byte   = byte_of(first_st, op_in, cmd_addr, cmd_wdata);
    adv_st       = next_state(state_q, op_q);
    adv_byte     = byte_of(adv_st, op_q, addr_q, wdata_q);
    poll_cnt_inc = poll_cnt_q + 10'd1;
    poll_done    = ~spi_rx[0] || (poll_cnt_inc >= PollMax);
    finish       = (state_q == StPollRd) ? poll_done : (adv_st == StResp);
  end

  always_ff @(posedge bus2ip_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      issue_q    <= 1'b0;
      op_q       <= CmdRead;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      poll_cnt_q <= 10'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_err    <= 1'b0;
      spi_hold   <= 1'b0;
      spi_tx     <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q                <= op_in;
            addr_q              <= cmd_addr;
            wdata_q             <= cmd_wdata;
            poll_cnt_q          <= 10'd0;
            state_q             <= first_st;
            issue_q             <= 1'b1;
            {spi_tx, spi_hold}  <= first_byte;
          end
        end
        StResp: state_q <= StIdle;
        default: begin
          if (issue_q) begin
            if (spi_ready) issue_q <= 1'b0;
          end else if (spi_rx_valid) begin
            if (state_q == StPollRd) poll_cnt_q <= poll_cnt_inc;
            if (finish) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= spi_rx;
              // Only a poll that stops with WIP still set is a timeout.
              rsp_err   <= (state_q == StPollRd) & spi_rx[0];
            end else begin
              state_q            <= adv_st;
              issue_q            <= 1'b1;
              {spi_tx, spi_hold} <= adv_byte;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Directed and randomized checks of the sequencer against a byte-engine model and a
// command-level reference model of the expected SPI byte stream and response.
`timescale 1ns / 1ps
module tb_spi_eeprom_sequencer;

  localparam int PM = 4;

  logic        bus2ip_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        spi_start;
  logic        spi_hold;
  logic [7:0]  spi_tx;
  logic        spi_ready = 1'b1;
  logic        spi_rx_valid = 1'b0;
  logic [7:0]  spi_rx = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Engine model state and the reference model's outputs.
  logic [8:0] log_q[$];
  logic [8:0] exp_seq[$];
  logic [7:0] rx_script[$];
  logic [7:0] sts_q[$];
  logic [7:0] exp_rdata;
  logic       exp_err;
  int         last_rx_cyc = 0;
  int         stall_idx = 0;
  bit         inject_rx = 0;

  spi_eeprom_sequencer #(.POLL_MAX(PM)) dut (
    .bus2ip_clk  (bus2ip_clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .spi_start   (spi_start),
    .spi_hold    (spi_hold),
    .spi_tx      (spi_tx),
    .spi_ready   (spi_ready),
    .spi_rx_valid(spi_rx_valid),
    .spi_rx      (spi_rx)
  );

  always #5 bus2ip_clk = ~bus2ip_clk;
  always @(posedge bus2ip_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte engine: samples at negedge, applies new inputs just after posedge.
  initial begin : engine
    bit         eng_busy;
    int         eng_cnt;
    int         block_cnt;
    bit         expect_start;
    bit         prev_start;
    logic [8:0] cur_byte;
    logic       n_valid;
    logic [7:0] n_rx;
    eng_busy = 0; eng_cnt = 0; block_cnt = 0; expect_start = 0; prev_start = 0;
    cur_byte = '0;
    forever begin
      @(negedge bus2ip_clk);
      n_valid = 1'b0;
      n_rx    = spi_rx;
      if (rst) begin
        eng_busy = 0; block_cnt = 0; expect_start = 0;
      end else begin
        if (expect_start) begin
          check("start_after_stall", spi_start, 1);
          expect_start = 0;
        end
        if (block_cnt > 0) begin
          block_cnt--;
          if (block_cnt == 0) expect_start = 1;
        end
        if (spi_start) begin
          check("start_while_ready", spi_ready, 1);
          check("start_not_back_to_back", prev_start, 0);
          cur_byte = {spi_tx, spi_hold};
          log_q.push_back(cur_byte);
          eng_busy = 1;
          eng_cnt  = $urandom_range(1, 3);
        end else if (eng_busy) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            check("tx_hold_stable", {spi_tx, spi_hold}, cur_byte);
            n_valid = 1'b1;
            n_rx = (rx_script.size() > 0) ? rx_script.pop_front() : 8'($urandom);
            eng_busy = 0;
            last_rx_cyc = cyc + 1;
            if (stall_idx != 0 && stall_idx == log_q.size()) begin
              block_cnt = 8;
              stall_idx = 0;
            end
          end
        end else if (inject_rx) begin
          n_valid   = 1'b1;
          n_rx      = 8'($urandom);
          inject_rx = 0;
        end
      end
      prev_start = spi_start;
      @(posedge bus2ip_clk);
      #1;
      spi_rx_valid = n_valid;
      spi_rx       = n_rx;
      spi_ready    = !eng_busy && (block_cnt == 0);
    end
  end

  // Reference model: expected (byte, hold) stream, engine replies and response.
  task automatic model(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] rd);
    exp_seq.delete();
    rx_script.delete();
    exp_err = 1'b0;
    case (op)
      2'b00: begin
        exp_seq = '{{8'h03, 1'b1}, {addr[15:8], 1'b1}, {addr[7:0], 1'b1}, {8'hFF, 1'b0}};
        rx_script = '{8'($urandom), 8'($urandom), 8'($urandom), rd};
        exp_rdata = rd;
      end
      2'b10: begin
        exp_seq = '{{8'h05, 1'b1}, {8'hFF, 1'b0}};
        rx_script = '{8'($urandom), sts_q[0]};
        exp_rdata = sts_q[0];
      end
      default: begin
        exp_seq.push_back({8'h06, 1'b0});
        if (op == 2'b01) begin
          exp_seq.push_back({8'h02, 1'b1});
          exp_seq.push_back({addr[15:8], 1'b1});
          exp_seq.push_back({addr[7:0], 1'b1});
        end else begin
          exp_seq.push_back({8'h01, 1'b1});
        end
        exp_seq.push_back({wd, 1'b0});
        repeat (exp_seq.size()) rx_script.push_back(8'($urandom));
        for (int i = 0; i < 1024; i++) begin
          exp_seq.push_back({8'h05, 1'b1});
          exp_seq.push_back({8'hFF, 1'b0});
          rx_script.push_back(8'($urandom));
          rx_script.push_back(sts_q[i]);
          exp_rdata = sts_q[i];
          if (!sts_q[i][0]) break;
          if (i + 1 >= PM) begin
            exp_err = 1'b1;
            break;
          end
        end
      end
    endcase
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd);
    int n;
    model(op, addr, wd, rd);
    log_q.delete();
    @(posedge bus2ip_clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    @(negedge bus2ip_clk);
    check({tag, "_ready_idle"}, cmd_ready, 1);
    @(posedge bus2ip_clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
    @(negedge bus2ip_clk);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_first_start"}, spi_start, 1);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge bus2ip_clk);
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1);
    if (rsp_valid) begin
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_err"}, rsp_err, exp_err);
      check({tag, "_busy_at_rsp"}, busy, 1);
      check({tag, "_rsp_latency"}, cyc, last_rx_cyc + 1);
      check({tag, "_seq_len"}, log_q.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < log_q.size(); i++)
        check({tag, "_seq_byte"}, log_q[i], exp_seq[i]);
      @(negedge bus2ip_clk);
      check({tag, "_ready_after"}, cmd_ready, 1);
      check({tag, "_rsp_one_cycle"}, rsp_valid, 0);
    end
  endtask

  task automatic gen_status();
    int n;
    sts_q.delete();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) sts_q.push_back(8'($urandom) | 8'h01);
    if ($urandom_range(0, 1) == 1) sts_q[n - 1] = sts_q[n - 1] & 8'hFE;
    else while (sts_q.size() < PM) sts_q.push_back(8'($urandom) | 8'h01);
  endtask

  initial begin : main
    int n;
    int accepts;
    int rsps;
    int acc_cyc[4];
    int rsp_cyc[4];
    logic [7:0] rsp_dat[4];
    logic [7:0] s1;
    logic [7:0] s2;
    bit saw;

    repeat (3) @(posedge bus2ip_clk);
    #1 rst = 1'b0;
    @(negedge bus2ip_clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_hold", spi_hold, 0);
    check("rst_spi_tx", spi_tx, 0);

    do_cmd("read", 2'b00, 16'h1234, 8'h00, 8'h5A);

    sts_q = '{8'h03, 8'h03, 8'h00};
    do_cmd("write", 2'b01, 16'h00FF, 8'hA5, 8'h00);

    sts_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    do_cmd("wrsr_timeout", 2'b11, 16'h0000, 8'h8C, 8'h00);

    stall_idx = 1;
    do_cmd("read_stall", 2'b00, 16'hBEEF, 8'h00, 8'hC3);
    check("stall_consumed", stall_idx, 0);

    // Spurious completion while idle.
    s1 = rsp_rdata;
    @(posedge bus2ip_clk); #1;
    inject_rx = 1;
    saw = 0;
    repeat (5) begin
      @(negedge bus2ip_clk);
      saw = saw | rsp_valid | spi_start | busy | !cmd_ready;
    end
    check("idle_spurious_rx", saw, 0);
    check("idle_rdata_kept", rsp_rdata, s1);

    // Reset during ADDR_LO of a READ.
    model(2'b00, 16'h4321, 8'h00, 8'h77);
    log_q.delete();
    @(posedge bus2ip_clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h4321;
    @(posedge bus2ip_clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (log_q.size() < 3 && n < 200) begin
      @(negedge bus2ip_clk);
      n++;
    end
    check("abort_reached_addr_lo", log_q.size(), 3);
    check("abort_hold_before", spi_hold, 1);
    @(posedge bus2ip_clk); #1 rst = 1'b1;
    @(posedge bus2ip_clk); #1 rst = 1'b0;
    rx_script.delete();
    @(negedge bus2ip_clk);
    check("abort_hold", spi_hold, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_start", spi_start, 0);
    saw = rsp_valid;
    repeat (4) begin
      @(negedge bus2ip_clk);
      saw = saw | rsp_valid;
    end
    check("abort_no_rsp", saw, 0);
    sts_q = '{8'h9E};
    do_cmd("rdsr_after_abort", 2'b10, 16'h0000, 8'h00, 8'h00);

    // cmd_valid held through two RDSR commands.
    s1 = 8'($urandom); s2 = 8'($urandom);
    rx_script = '{8'($urandom), s1, 8'($urandom), s2};
    log_q.delete();
    accepts = 0; rsps = 0;
    @(posedge bus2ip_clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b10;
    for (int i = 0; i < 300 && rsps < 2; i++) begin
      @(negedge bus2ip_clk);
      if (cmd_valid && cmd_ready) begin
        if (accepts < 4) acc_cyc[accepts] = cyc;
        accepts++;
      end
      if (rsp_valid) begin
        if (rsps < 4) begin
          rsp_cyc[rsps] = cyc;
          rsp_dat[rsps] = rsp_rdata;
        end
        rsps++;
      end
    end
    @(posedge bus2ip_clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge bus2ip_clk);
    check("b2b_rsps", rsps, 2);
    check("b2b_accepts", accepts, 2);
    if (rsps == 2 && accepts == 2) begin
      check("b2b_gap", acc_cyc[1], rsp_cyc[0] + 1);
      check("b2b_rdata0", rsp_dat[0], s1);
      check("b2b_rdata1", rsp_dat[1], s2);
    end
    check("b2b_idle_after", busy, 0);

    // Randomized commands against the reference model.
    for (int k = 0; k < 12; k++) begin
      gen_status();
      do_cmd("rand", 2'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
